// File: rtl/botsw_drv_pkg.sv
// Shared state encoding and parameter defaults for the bottom-switch gate driver.
package botsw_drv_pkg;

    localparam int unsigned DT_CYCLES_DEF     = 4;
    localparam int unsigned MIN_ON_CYCLES_DEF = 8;
    localparam int unsigned MAX_ON_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        DT_ON,
        ON,
        DT_OFF,
        FAULT
    } bsw_state_e;

endpackage

// File: rtl/botsw_sync2.sv
// Two-flop synchroniser for asynchronous sense inputs; clears to 0 on reset.
module botsw_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/botsw_gate_sequencer.sv
// Bottom-FET gate sequencer: dead time, min/max on-time, zero-cross turn-off
// and shoot-through latch, with every output registered alongside the state.
module botsw_gate_sequencer
    import botsw_drv_pkg::*;
#(
    parameter int unsigned DT_CYCLES     = DT_CYCLES_DEF,
    parameter int unsigned MIN_ON_CYCLES = MIN_ON_CYCLES_DEF,
    parameter int unsigned MAX_ON_CYCLES = MAX_ON_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic low_req,
    input  logic top_gate_fb,
    input  logic zc_det,
    output logic gate,
    output logic bot_safe,
    output logic zc_off,
    output logic max_on,
    output logic shoot_fault
);

    localparam int unsigned CW = $clog2(MAX_ON_CYCLES + 1);
    localparam logic [CW-1:0] DT_LAST  = CW'(DT_CYCLES - 1);
    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_ON_CYCLES - 1);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_ON_CYCLES - 1);

    logic top_s;
    logic zc_s;

    botsw_sync2 u_sync_top (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (top_gate_fb),
        .q_o   (top_s)
    );

    botsw_sync2 u_sync_zc (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (zc_det),
        .q_o   (zc_s)
    );

    bsw_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gate_q, gate_d;
    logic          safe_q, safe_d;
    logic          zc_off_q, zc_off_d;
    logic          max_on_q, max_on_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_inc;
    logic          min_done;

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    assign min_done = (cnt_q >= MIN_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        zc_off_d = 1'b0;
        max_on_d = 1'b0;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && low_req && !top_s) begin
                    state_d = DT_ON;
                end
            end
            DT_ON: begin
                if (!en || !low_req || top_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DT_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                // Exit priority: shoot-through, disable, max-on, zero-cross, request drop.
                if (top_s) begin
                    state_d = FAULT;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end else if (!en) begin
                    state_d = DT_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == MAX_LAST) begin
                    state_d  = DT_OFF;
                    cnt_d    = '0;
                    max_on_d = 1'b1;
                end else if (min_done && zc_s) begin
                    state_d  = DT_OFF;
                    cnt_d    = '0;
                    zc_off_d = 1'b1;
                end else if (min_done && !low_req) begin
                    state_d = DT_OFF;
                    cnt_d   = '0;
                end
            end
            DT_OFF: begin
                if (cnt_q == DT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            FAULT: begin
                cnt_d = '0;
                if (!en) begin
                    state_d = DT_OFF;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = DT_OFF;
                cnt_d   = '0;
            end
        endcase
        gate_d = (state_d == ON);
        safe_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DT_OFF;
            cnt_q    <= '0;
            gate_q   <= 1'b0;
            safe_q   <= 1'b0;
            zc_off_q <= 1'b0;
            max_on_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gate_q   <= gate_d;
            safe_q   <= safe_d;
            zc_off_q <= zc_off_d;
            max_on_q <= max_on_d;
            fault_q  <= fault_d;
        end
    end

    assign gate        = gate_q;
    assign bot_safe    = safe_q;
    assign zc_off      = zc_off_q;
    assign max_on      = max_on_q;
    assign shoot_fault = fault_q;

endmodule

// File: tb/tb_botsw_gate_sequencer.sv
// Scoreboard bench for botsw_gate_sequencer with DT=4, MIN_ON=8, MAX_ON=64.
module tb_botsw_gate_sequencer;

    localparam int DT  = 4;
    localparam int MIN = 8;
    localparam int MAX = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic low_req;
    logic top_gate_fb;
    logic zc_det;
    logic gate;
    logic bot_safe;
    logic zc_off;
    logic max_on;
    logic shoot_fault;

    always #5 clk = ~clk;

    botsw_gate_sequencer #(
        .DT_CYCLES     (DT),
        .MIN_ON_CYCLES (MIN),
        .MAX_ON_CYCLES (MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .low_req     (low_req),
        .top_gate_fb (top_gate_fb),
        .zc_det      (zc_det),
        .gate        (gate),
        .bot_safe    (bot_safe),
        .zc_off      (zc_off),
        .max_on      (max_on),
        .shoot_fault (shoot_fault)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   zc_seen  = 0;
    int   mo_seen  = 0;

    always @(negedge clk) begin
        if (zc_off === 1'b1) zc_seen++;
        if (max_on === 1'b1) mo_seen++;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic expect_next(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic score(input int obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", obs, -999);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    function automatic int sig(input int which);
        case (which)
            0:       return int'(gate);
            1:       return int'(bot_safe);
            2:       return int'(shoot_fault);
            3:       return int'(zc_off);
            default: return int'(max_on);
        endcase
    endfunction

    // Negedges until the chosen output reaches val; -1 if the bound expires.
    task automatic wait_sig(input int which, input int val, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sig(which) == val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int g;
        rst_n       = 1'b0;
        en          = 1'b0;
        low_req     = 1'b0;
        top_gate_fb = 1'b0;
        zc_det      = 1'b0;
        step(3);

        // Reset state
        expect_next("rst_gate", 0);
        expect_next("rst_safe", 0);
        expect_next("rst_fault", 0);
        expect_next("rst_zc", 0);
        expect_next("rst_max", 0);
        for (int w = 0; w < 5; w++) score(sig(w));
        expect_next("rst_safe_delay", DT);
        rst_n = 1'b1;
        wait_sig(1, 1, 20, n);
        score(n);

        // Normal cycle, request dropped before min-on expires
        expect_next("t2_exit", 1);
        expect_next("t2_rise", DT);
        expect_next("t2_high", MIN);
        expect_next("t2_safe", DT);
        expect_next("t2_fault", 0);
        en      = 1'b1;
        low_req = 1'b1;
        wait_sig(1, 0, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        step(3);
        low_req = 1'b0;
        wait_sig(0, 0, 20, n);
        score(n < 0 ? n : n + 3);
        wait_sig(1, 1, 10, n);
        score(n);
        score(sig(2));

        // Top feedback during DT_ON aborts back to IDLE
        expect_next("t3_exit", 1);
        expect_next("t3_gate_seen", 0);
        expect_next("t3_safe", 1);
        expect_next("t3_fault", 0);
        low_req = 1'b1;
        wait_sig(1, 0, 10, n);
        score(n);
        top_gate_fb = 1'b1;
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (gate !== 1'b0) g = 1;
        end
        score(g);
        score(sig(1));
        score(sig(2));
        top_gate_fb = 1'b0;
        low_req     = 1'b0;
        step(4);

        // Zero-cross turn-off, then re-arm with request still high
        expect_next("t4_exit", 1);
        expect_next("t4_rise", DT);
        expect_next("t4_zc_lat", 3);
        expect_next("t4_zc_pulse", 1);
        expect_next("t4_safe", DT);
        expect_next("t4_rearm", DT + 1);
        expect_next("t4_tail", MIN + DT);
        low_req = 1'b1;
        wait_sig(1, 0, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        step(10);
        zc_det = 1'b1;
        wait_sig(0, 0, 20, n);
        score(n);
        score(sig(3));
        zc_det = 1'b0;
        wait_sig(1, 1, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        low_req = 1'b0;
        wait_sig(1, 1, 40, n);
        score(n);

        // Max-on forced turn-off, then re-arm
        expect_next("t5_exit", 1);
        expect_next("t5_rise", DT);
        expect_next("t5_high", MAX);
        expect_next("t5_pulse", 1);
        expect_next("t5_safe", DT);
        expect_next("t5_rearm", DT + 1);
        expect_next("t5_tail", MIN + DT);
        low_req = 1'b1;
        wait_sig(1, 0, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        wait_sig(0, 0, 200, n);
        score(n);
        score(sig(4));
        wait_sig(1, 1, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        low_req = 1'b0;
        wait_sig(1, 1, 40, n);
        score(n);

        // Shoot-through while ON: sticky until en drops
        expect_next("t6_exit", 1);
        expect_next("t6_rise", DT);
        expect_next("t6_off_lat", 3);
        expect_next("t6_fault_set", 1);
        expect_next("t6_hold_gate", 0);
        expect_next("t6_hold_safe", 0);
        expect_next("t6_hold_fault", 1);
        expect_next("t6_sticky", 1);
        expect_next("t6_clear", 1);
        expect_next("t6_safe", DT);
        low_req = 1'b1;
        wait_sig(1, 0, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        step(2);
        top_gate_fb = 1'b1;
        wait_sig(0, 0, 10, n);
        score(n);
        score(sig(2));
        step(5);
        score(sig(0));
        score(sig(1));
        score(sig(2));
        top_gate_fb = 1'b0;
        step(4);
        score(sig(2));
        en = 1'b0;
        wait_sig(2, 0, 10, n);
        score(n);
        wait_sig(1, 1, 10, n);
        score(n);
        low_req = 1'b0;
        step(2);

        // Disable while ON ignores min-on
        expect_next("t7_exit", 1);
        expect_next("t7_rise", DT);
        expect_next("t7_off", 1);
        expect_next("t7_safe", DT);
        en      = 1'b1;
        low_req = 1'b1;
        wait_sig(1, 0, 10, n);
        score(n);
        wait_sig(0, 1, 10, n);
        score(n);
        step(2);
        en = 1'b0;
        wait_sig(0, 0, 10, n);
        score(n);
        low_req = 1'b0;
        wait_sig(1, 1, 10, n);
        score(n);

        // Pulse totals over the whole run
        step(2);
        expect_next("zc_total", 1);
        expect_next("max_total", 1);
        score(zc_seen);
        score(mo_seen);
        chk("sb_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
